uart_rx_ctrl_v2: RTL and testbench

Self-contained UART receive controller. It replaces the separate control-FSM, edge/bit-counter and sampler arrangement with a single block that owns the oversampling counters, majority-vote sampling, deserialisation and parity/stop checking. Frame format is parametrised in data width and runtime-configurable in prescale, parity (enable/type) and stop-bit count. It sits between the synchronised RX line and the register-file/system-control consumer of received bytes.

---
 rtl/uart_rx_ctrl_v2_if.sv | 27 ++
 rtl/uart_rx_ctrl_v2.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl_v2.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_v2_if.sv
// UART receiver bundle: serial line and frame configuration in, received word and status out.
interface uart_rx_ctrl_v2_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  Parity_EN;
    logic                  Parity_TYP;
    logic                  Two_stop;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Parity_error;
    logic                  Stop_error;
    logic                  Busy;
    logic                  Break_det;

    modport master (
        output RX_IN, Prescale, Parity_EN, Parity_TYP, Two_stop,
        input  P_DATA, Data_valid, Parity_error, Stop_error, Busy, Break_det
    );

    modport slave (
        input  RX_IN, Prescale, Parity_EN, Parity_TYP, Two_stop,
        output P_DATA, Data_valid, Parity_error, Stop_error, Busy, Break_det
    );
endinterface

// File: rtl/uart_rx_ctrl_v2.sv
// UART receive controller: oversampled majority-vote sampling, deserialisation,
// parity and stop checking. Optional break detection under UART_RX_BREAK_DET_EN.
module uart_rx_ctrl_v2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input logic              CLK,
    input logic              Reset,
    uart_rx_ctrl_v2_if.slave bus
);
    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT
    } state_t;

    state_t                state_q, state_n;
    logic [PRESCALE_W-1:0] edge_q, edge_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [2:0]            samp_q, samp_n;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic [PRESCALE_W-1:0] pre_q, pre_n;
    logic                  pen_q, pen_n;
    logic                  ptyp_q, ptyp_n;
    logic                  two_q, two_n;
    logic                  perr_q, perr_n;
    logic                  serr_q, serr_n;
    logic                  stop2_q, stop2_n;
`ifdef UART_RX_BREAK_DET_EN
    logic                  zero_q, zero_n;
`endif
    logic [DATA_WIDTH-1:0] p_data_q, p_data_n;
    logic                  dv_q, dv_n;
    logic                  pe_q, pe_n;
    logic                  se_q, se_n;
    logic                  busy_q, busy_n;
    logic                  brk_q, brk_n;

    logic [PRESCALE_W-1:0] half_c;
    logic                  in_frame_c;
    logic                  last_edge_c;
    logic                  decide_c;
    logic                  vote_c;

    // Bit-timing strobes derived from the latched prescale
    assign half_c      = pre_q >> 1;
    assign in_frame_c  = (state_q == START) || (state_q == DATA) ||
                         (state_q == PARITY) || (state_q == STOP);
    assign last_edge_c = (edge_q == pre_q - PRESCALE_W'(1));
    assign decide_c    = in_frame_c && (edge_q == half_c + PRESCALE_W'(2));
    assign vote_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                         (samp_q[1] & samp_q[2]);

    // State, counters, shadow config and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            edge_q   <= '0;
            bit_q    <= '0;
            samp_q   <= '0;
            shreg_q  <= '0;
            pre_q    <= '0;
            pen_q    <= 1'b0;
            ptyp_q   <= 1'b0;
            two_q    <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            stop2_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q   <= 1'b0;
`endif
            p_data_q <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
            busy_q   <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            edge_q   <= edge_n;
            bit_q    <= bit_n;
            samp_q   <= samp_n;
            shreg_q  <= shreg_n;
            pre_q    <= pre_n;
            pen_q    <= pen_n;
            ptyp_q   <= ptyp_n;
            two_q    <= two_n;
            perr_q   <= perr_n;
            serr_q   <= serr_n;
            stop2_q  <= stop2_n;
`ifdef UART_RX_BREAK_DET_EN
            zero_q   <= zero_n;
`endif
            p_data_q <= p_data_n;
            dv_q     <= dv_n;
            pe_q     <= pe_n;
            se_q     <= se_n;
            busy_q   <= busy_n;
            brk_q    <= brk_n;
        end
    end

    // Next-state, sampling, shifting and end-of-frame result computation
    always_comb begin
        state_n  = state_q;
        edge_n   = '0;
        bit_n    = bit_q;
        samp_n   = samp_q;
        shreg_n  = shreg_q;
        pre_n    = pre_q;
        pen_n    = pen_q;
        ptyp_n   = ptyp_q;
        two_n    = two_q;
        perr_n   = perr_q;
        serr_n   = serr_q;
        stop2_n  = stop2_q;
`ifdef UART_RX_BREAK_DET_EN
        zero_n   = zero_q;
`endif
        p_data_n = p_data_q;
        dv_n     = 1'b0;
        pe_n     = 1'b0;
        se_n     = 1'b0;
        brk_n    = 1'b0;

        if (in_frame_c) begin
            edge_n = last_edge_c ? '0 : edge_q + PRESCALE_W'(1);
            if (edge_q == half_c - PRESCALE_W'(1)) samp_n[0] = bus.RX_IN;
            if (edge_q == half_c)                  samp_n[1] = bus.RX_IN;
            if (edge_q == half_c + PRESCALE_W'(1)) samp_n[2] = bus.RX_IN;
        end

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_n = START;
                    pre_n   = bus.Prescale;
                    pen_n   = bus.Parity_EN;
                    ptyp_n  = bus.Parity_TYP;
                    two_n   = bus.Two_stop;
                    perr_n  = 1'b0;
                    serr_n  = 1'b0;
                    stop2_n = 1'b0;
                    bit_n   = '0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_n  = 1'b1;
`endif
                end
            end
            START: begin
                if (decide_c && vote_c) state_n = IDLE;
                else if (last_edge_c)   state_n = DATA;
            end
            DATA: begin
                if (decide_c) begin
                    shreg_n = {vote_c, shreg_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    if (vote_c) zero_n = 1'b0;
`endif
                end
                if (last_edge_c) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_n = pen_q ? PARITY : STOP;
                    else                                 bit_n = bit_q + BIT_W'(1);
                end
            end
            PARITY: begin
                if (decide_c) begin
                    if (vote_c != ((^shreg_q) ^ ptyp_q)) perr_n = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    if (vote_c) zero_n = 1'b0;
`endif
                end
                if (last_edge_c) state_n = STOP;
            end
            STOP: begin
                if (decide_c) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (!stop2_q && zero_q && !vote_c) begin
                        state_n = DONE;
                        brk_n   = 1'b1;
                    end else
`endif
                    if (two_q && !stop2_q) begin
                        serr_n = serr_q | ~vote_c;
                    end else begin
                        state_n = DONE;
                        pe_n    = perr_q;
                        se_n    = serr_q | ~vote_c;
                        if (!perr_q && vote_c && !serr_q) begin
                            dv_n     = 1'b1;
                            p_data_n = shreg_q;
                        end
                    end
                end
                // Only a first-of-two stop bit runs to its last edge
                if (last_edge_c) stop2_n = 1'b1;
            end
            DONE: begin
`ifdef UART_RX_BREAK_DET_EN
                state_n = brk_q ? BREAK_WAIT : IDLE;
`else
                state_n = IDLE;
`endif
            end
            BREAK_WAIT: begin
                if (bus.RX_IN) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if ((state_n == IDLE) || (state_n == DONE) || (state_n == BREAK_WAIT)) edge_n = '0;
        busy_n = (state_n != IDLE);
    end

    assign bus.P_DATA       = p_data_q;
    assign bus.Data_valid   = dv_q;
    assign bus.Parity_error = pe_q;
    assign bus.Stop_error   = se_q;
    assign bus.Busy         = busy_q;
    assign bus.Break_det    = brk_q;
endmodule

// File: tb/tb_uart_rx_ctrl_v2.sv
// Self-checking bench for uart_rx_ctrl_v2: frame-level model predicts pulse cycles and busy windows.
module tb_uart_rx_ctrl_v2;
    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic       brk;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;
    logic rst_s;
    logic [7:0] pd_m = '0;
    int   dv_seen = 0, pe_seen = 0, se_seen = 0, brk_seen = 0;
    ev_t  evq[$];
    win_t wq[$];

    uart_rx_ctrl_v2_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_ctrl_v2 #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Per-cycle comparison of every output against the frame-level model
    initial begin
        ev_t  ev;
        logic e_dv, e_pe, e_se, e_brk, e_busy;
        forever begin
            @(posedge clk);
            rst_s = rst;
            cyc   = cyc + 1;
            #1;
            if (rst_s) begin
                evq.delete();
                wq.delete();
                pd_m = '0;
            end
            e_dv = 0; e_pe = 0; e_se = 0; e_brk = 0; e_busy = 0;
            while (wq.size() > 0 && wq[0].hi < cyc) void'(wq.pop_front());
            foreach (wq[i]) if (wq[i].lo <= cyc && cyc <= wq[i].hi) e_busy = 1;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                e_dv = ev.dv; e_pe = ev.pe; e_se = ev.se; e_brk = ev.brk;
                if (ev.dv) pd_m = ev.data;
            end
            if (chk_en) begin
                chk("Data_valid",   32'(bus.Data_valid),   32'(e_dv));
                chk("Parity_error", 32'(bus.Parity_error), 32'(e_pe));
                chk("Stop_error",   32'(bus.Stop_error),   32'(e_se));
                chk("Break_det",    32'(bus.Break_det),    32'(e_brk));
                chk("Busy",         32'(bus.Busy),         32'(e_busy));
                chk("P_DATA",       32'(bus.P_DATA),       32'(pd_m));
                if (bus.Data_valid === 1'b1)   dv_seen++;
                if (bus.Parity_error === 1'b1) pe_seen++;
                if (bus.Stop_error === 1'b1)   se_seen++;
                if (bus.Break_det === 1'b1)    brk_seen++;
            end
        end
    end

    // Drive one frame from the current negedge and record its expected outcome
    task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                              input logic ptyp, input logic two, input logic bad_par,
                              input logic stop2_val, input logic poke,
                              output int k_o, output int done_o);
        logic [11:0] bits;
        int          nbits;
        ev_t         ev;
        bits = '1;
        bus.Prescale   = 6'(p);
        bus.Parity_EN  = pen;
        bus.Parity_TYP = ptyp;
        bus.Two_stop   = two;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        nbits = 9;
        if (pen) begin
            bits[nbits] = (^data) ^ ptyp ^ bad_par;
            nbits++;
        end
        bits[nbits] = 1'b1;
        nbits++;
        if (two) begin
            bits[nbits] = stop2_val;
            nbits++;
        end
        k_o    = cyc + 1;
        done_o = k_o + (nbits - 1) * p + p / 2 + 3;
        ev.cyc = done_o;
        ev.pe  = pen & bad_par;
        ev.se  = two & ~stop2_val;
        ev.dv  = ~ev.pe & ~ev.se;
        ev.brk = 1'b0;
        ev.data = data;
        evq.push_back(ev);
        wq.push_back('{k_o, done_o});
        for (int i = 0; i < nbits; i++) begin
            bus.RX_IN = bits[i];
            if (poke && i == 1) begin
                bus.Prescale   = 6'd16;
                bus.Parity_EN  = ~pen;
                bus.Parity_TYP = ~ptyp;
                bus.Two_stop   = ~two;
            end
            repeat (p) @(negedge clk);
        end
        bus.RX_IN      = 1'b1;
        bus.Prescale   = 6'(p);
        bus.Parity_EN  = pen;
        bus.Parity_TYP = ptyp;
        bus.Two_stop   = two;
    endtask

    initial begin
        int k, d, k2, d2, dv0, pe0, se0, brk0;
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        bus.Prescale = 6'd8;
        bus.Parity_EN = 1'b0;
        bus.Parity_TYP = 1'b0;
        bus.Two_stop = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_P_DATA", 32'(bus.P_DATA), 32'h0);
        chk("reset_Busy",   32'(bus.Busy),   32'h0);

        // 1: 0xA5, P=8, 8N1, config poked mid-frame must be ignored
        dv0 = dv_seen;
        send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, k, d);
        chk("t1_done_offset", 32'(d - k), 32'd79);
        chk("t1_P_DATA",      32'(bus.P_DATA), 32'hA5);
        chk("t1_dv_count",    32'(dv_seen - dv0), 32'd1);
        repeat (5) @(negedge clk);

        // 2: even parity, wrong parity bit -> Parity_error only, P_DATA kept
        dv0 = dv_seen; pe0 = pe_seen;
        send_frame(8'h3C, 8, 1, 0, 0, 1, 1, 0, k, d);
        chk("t2_pe_count", 32'(pe_seen - pe0), 32'd1);
        chk("t2_dv_count", 32'(dv_seen - dv0), 32'd0);
        chk("t2_P_DATA",   32'(bus.P_DATA), 32'hA5);
        repeat (5) @(negedge clk);

        // Good parity frames: odd with 0x3C, even with 0x07
        send_frame(8'h3C, 8, 1, 1, 0, 0, 1, 0, k, d);
        chk("odd_par_P_DATA", 32'(bus.P_DATA), 32'h3C);
        repeat (3) @(negedge clk);
        send_frame(8'h07, 16, 1, 0, 0, 0, 1, 0, k, d);
        chk("even_par_P_DATA", 32'(bus.P_DATA), 32'h07);
        repeat (3) @(negedge clk);

        // 3: two-clock glitch at P=16 -> START aborted
        dv0 = dv_seen; pe0 = pe_seen; se0 = se_seen;
        bus.Prescale = 6'd16;
        bus.RX_IN = 1'b0;
        k = cyc + 1;
        wq.push_back('{k, k + 16 / 2 + 2});
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_pulses", 32'((dv_seen - dv0) + (pe_seen - pe0) + (se_seen - se0)), 32'd0);
        chk("t3_Busy",   32'(bus.Busy), 32'h0);

        // 4: two stop bits, second stop low -> Stop_error only
        dv0 = dv_seen; pe0 = pe_seen; se0 = se_seen;
        send_frame(8'h5A, 8, 0, 0, 1, 0, 0, 0, k, d);
        chk("t4_se_count", 32'(se_seen - se0), 32'd1);
        chk("t4_pe_count", 32'(pe_seen - pe0), 32'd0);
        chk("t4_dv_count", 32'(dv_seen - dv0), 32'd0);
        repeat (5) @(negedge clk);

        // 5: reset during data bit 3, then a clean 0x55
        bus.Prescale = 6'd8; bus.Parity_EN = 1'b0; bus.Two_stop = 1'b0;
        k = cyc + 1;
        wq.push_back('{k, k + 100000});
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = (i % 2 == 1);
            repeat (8) @(negedge clk);
        end
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_Busy",   32'(bus.Busy), 32'h0);
        chk("t5_rst_P_DATA", 32'(bus.P_DATA), 32'h0);
        repeat (3) @(negedge clk);
        dv0 = dv_seen;
        send_frame(8'h55, 8, 0, 0, 0, 0, 1, 0, k, d);
        chk("t5_P_DATA",   32'(bus.P_DATA), 32'h55);
        chk("t5_dv_count", 32'(dv_seen - dv0), 32'd1);
        repeat (5) @(negedge clk);

        // 6: back-to-back 0x01, 0xFE at P=32 with no idle gap
        dv0 = dv_seen;
        send_frame(8'h01, 32, 0, 0, 0, 0, 1, 0, k, d);
        send_frame(8'hFE, 32, 0, 0, 0, 0, 1, 0, k2, d2);
        chk("t6_gap",      32'(d2 - d), 32'd320);
        chk("t6_dv_count", 32'(dv_seen - dv0), 32'd2);
        chk("t6_P_DATA",   32'(bus.P_DATA), 32'hFE);
        repeat (5) @(negedge clk);

`ifdef UART_RX_BREAK_DET_EN
        // Break: line low for two frame-times at P=32
        begin
            ev_t ev;
            brk0 = brk_seen; se0 = se_seen;
            bus.Prescale = 6'd32;
            bus.RX_IN = 1'b0;
            k = cyc + 1;
            ev.cyc = k + 9 * 32 + 16 + 3;
            ev.dv = 0; ev.pe = 0; ev.se = 0; ev.brk = 1; ev.data = 8'h00;
            evq.push_back(ev);
            wq.push_back('{k, k + 20 * 32 - 1});
            repeat (20 * 32) @(negedge clk);
            bus.RX_IN = 1'b1;
            repeat (10) @(negedge clk);
            chk("brk_count", 32'(brk_seen - brk0), 32'd1);
            chk("brk_se",    32'(se_seen - se0), 32'd0);
        end
`else
        brk0 = brk_seen;
        chk("no_brk_count", 32'(brk_seen - brk0 + brk_seen), 32'd0);
`endif

        repeat (10) @(negedge clk);
        chk("evq_drained", 32'(evq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
